// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared widths, open-bus value and request decode for the 8088 core bus
package core_pkg;

    localparam int ADDR_W = 20;
    localparam int PORT_W = 16;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] OPEN_BUS = 8'hFF;

    typedef enum logic [1:0] {
        REQ_MEM_RD,
        REQ_MEM_WR,
        REQ_IO_RD,
        REQ_IO_WR
    } req_kind_t;

    // Port write wins over port read, which wins over memory write.
    function automatic req_kind_t decode_req(input logic pw, input logic pr, input logic we);
        req_kind_t kind;
        if (pw) begin
            kind = REQ_IO_WR;
        end else if (pr) begin
            kind = REQ_IO_RD;
        end else if (we) begin
            kind = REQ_MEM_WR;
        end else begin
            kind = REQ_MEM_RD;
        end
        return kind;
    endfunction

endpackage

// File: rtl/core_bus.sv
// rtl/core_bus.sv - paces the 8088 core with ce and runs one memory or port transaction per step
module core_bus
    import core_pkg::*;
#(
    parameter int DIV     = 3,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              ce,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] core_out,
    input  logic              core_we,
    input  logic              core_pr,
    input  logic              core_pw,
    output logic [DATA_W-1:0] core_in,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_req,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [PORT_W-1:0] io_port,
    output logic [DATA_W-1:0] io_wdata,
    output logic              io_rd,
    output logic              io_wr,
    input  logic [DATA_W-1:0] io_rdata,
    input  logic              io_ack,
    output logic              bus_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM,
        S_IO,
        S_HOLD,
        S_STEP
    } state_t;

    localparam int STEP_W = $clog2(DIV + 2);
    localparam int TO_W   = $clog2(TIMEOUT + 2);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'((DIV > 1) ? (DIV - 1) : 0);
    localparam logic [STEP_W-1:0] STEP_MAX  = '1;
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT);
    // The shortest path IDLE-MEM-STEP already spans three clocks.
    localparam bit THROTTLE = (DIV > 3);

    state_t            state;
    state_t            state_next;
    req_kind_t         kind;
    req_kind_t         req_next;
    logic [STEP_W-1:0] step_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              ack_hit;
    logic              to_hit;
    logic              step_ok;

    assign ce = (state == S_STEP);

    always_comb begin
        state_next = state;
        req_next   = decode_req(core_pw, core_pr, core_we);
        ack_hit    = 1'b0;
        to_hit     = 1'b0;
        step_ok    = !THROTTLE || (step_cnt >= STEP_LAST);
        case (state)
            S_IDLE: begin
                state_next = ((req_next == REQ_IO_RD) || (req_next == REQ_IO_WR)) ? S_IO : S_MEM;
            end
            S_MEM, S_IO: begin
                // Only the ack of the bus that carries the request counts.
                ack_hit = (state == S_MEM) ? mem_ack : io_ack;
                to_hit  = !ack_hit && (to_cnt == TO_LAST);
                if (ack_hit || to_hit) begin
                    state_next = step_ok ? S_STEP : S_HOLD;
                end
            end
            S_HOLD: begin
                if (step_ok) begin
                    state_next = S_STEP;
                end
            end
            S_STEP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            kind        <= REQ_MEM_RD;
            step_cnt    <= '0;
            to_cnt      <= '0;
            core_in     <= OPEN_BUS;
            mem_address <= '0;
            mem_wdata   <= '0;
            io_port     <= '0;
            io_wdata    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            io_rd       <= 1'b0;
            io_wr       <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            state   <= state_next;
            bus_err <= to_hit;

            // Counts clocks since the last STEP; saturates so long stalls cannot wrap.
            if (state == S_STEP) begin
                step_cnt <= STEP_W'(1);
            end else if (step_cnt != STEP_MAX) begin
                step_cnt <= step_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    kind        <= req_next;
                    mem_address <= address;
                    io_port     <= address[PORT_W-1:0];
                    mem_wdata   <= core_out;
                    io_wdata    <= core_out;
                    to_cnt      <= '0;
                    mem_req     <= (req_next == REQ_MEM_RD) || (req_next == REQ_MEM_WR);
                    mem_we      <= (req_next == REQ_MEM_WR);
                    io_rd       <= (req_next == REQ_IO_RD);
                    io_wr       <= (req_next == REQ_IO_WR);
                end
                S_MEM, S_IO: begin
                    if (ack_hit || to_hit) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        io_rd   <= 1'b0;
                        io_wr   <= 1'b0;
                        if (to_hit) begin
                            core_in <= OPEN_BUS;
                        end else begin
                            case (kind)
                                REQ_MEM_RD: core_in <= mem_rdata;
                                REQ_MEM_WR: core_in <= core_out;
                                REQ_IO_RD:  core_in <= io_rdata;
                                default:    ;
                            endcase
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_bus.sv
// tb/tb_core_bus.sv - table-driven scoreboard bench for core_bus
module tb_core_bus;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        ce;
    logic [19:0] address;
    logic [7:0]  core_out;
    logic        core_we, core_pr, core_pw;
    logic [7:0]  core_in;
    logic [19:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we, mem_req;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [15:0] io_port;
    logic [7:0]  io_wdata;
    logic        io_rd, io_wr;
    logic [7:0]  io_rdata;
    logic        io_ack;
    logic        bus_err;

    core_bus #(.DIV(3), .TIMEOUT(4)) u_dut (
        .clock(clock), .reset_n(reset_n), .ce(ce),
        .address(address), .core_out(core_out),
        .core_we(core_we), .core_pr(core_pr), .core_pw(core_pw),
        .core_in(core_in),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_req(mem_req),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .io_port(io_port), .io_wdata(io_wdata), .io_rd(io_rd), .io_wr(io_wr),
        .io_rdata(io_rdata), .io_ack(io_ack),
        .bus_err(bus_err)
    );

    logic        b_reset_n;
    logic        b_ce;
    logic [19:0] b_address;
    logic [7:0]  b_core_out;
    logic        b_core_we, b_core_pr, b_core_pw;
    logic [7:0]  b_core_in;
    logic [19:0] b_mem_address;
    logic [7:0]  b_mem_wdata;
    logic        b_mem_we, b_mem_req;
    logic [7:0]  b_mem_rdata;
    logic        b_mem_ack;
    logic [15:0] b_io_port;
    logic [7:0]  b_io_wdata;
    logic        b_io_rd, b_io_wr;
    logic [7:0]  b_io_rdata;
    logic        b_io_ack;
    logic        b_bus_err;

    core_bus #(.DIV(10), .TIMEOUT(255)) u_throttle (
        .clock(clock), .reset_n(b_reset_n), .ce(b_ce),
        .address(b_address), .core_out(b_core_out),
        .core_we(b_core_we), .core_pr(b_core_pr), .core_pw(b_core_pw),
        .core_in(b_core_in),
        .mem_address(b_mem_address), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_req(b_mem_req),
        .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
        .io_port(b_io_port), .io_wdata(b_io_wdata), .io_rd(b_io_rd), .io_wr(b_io_wr),
        .io_rdata(b_io_rdata), .io_ack(b_io_ack),
        .bus_err(b_bus_err)
    );

    // Zero-wait device: memory byte equals the low address byte.
    assign b_mem_ack   = b_mem_req;
    assign b_mem_rdata = b_mem_address[7:0];
    assign b_io_ack    = b_io_rd | b_io_wr;
    assign b_io_rdata  = 8'h00;

    typedef struct {
        logic        pw, pr, we;
        logic [19:0] addr;
        logic [7:0]  wdata;
        int          waits;
        logic [7:0]  rdata;
        bit          spur;
        int          exp_lat;
        logic [7:0]  exp_core_in;
        int          exp_kind;
        int          exp_req_clks;
        int          exp_err;
    } vec_t;

    vec_t       exp_q[$];
    vec_t       cur;
    logic [7:0] b_exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        address   = v.addr;
        core_out  = v.wdata;
        core_we   = v.we;
        core_pr   = v.pr;
        core_pw   = v.pw;
        mem_rdata = v.rdata;
        io_rdata  = v.rdata;
        mem_ack   = 1'b0;
        io_ack    = 1'b0;
        cur       = v;
        exp_q.push_back(v);
    endtask

    task automatic wait_step(input string tag);
        vec_t        e;
        int          lat = 0;
        int          wcnt = 0;
        int          req_clks = 0;
        int          errs = 0;
        int          obs_kind;
        bit          s_mem = 0, s_rd = 0, s_wr = 0, s_we = 0, got = 0;
        logic [19:0] o_addr = '0;
        logic [19:0] e_addr;
        logic [7:0]  o_wd = '0;
        while (lat < 50) begin
            @(negedge clock);
            lat++;
            if (mem_req) begin s_mem = 1; s_we = mem_we; o_addr = mem_address; o_wd = mem_wdata; req_clks++; end
            if (io_rd)   begin s_rd = 1; o_addr = {4'h0, io_port}; req_clks++; end
            if (io_wr)   begin s_wr = 1; o_addr = {4'h0, io_port}; o_wd = io_wdata; req_clks++; end
            if (bus_err) errs++;
            if (ce) begin got = 1; break; end
            mem_ack = 1'b0;
            io_ack  = 1'b0;
            if (cur.spur && lat == 1) mem_ack = 1'b1;
            if ((mem_req || io_rd || io_wr) && cur.waits >= 0) begin
                if (wcnt == cur.waits) begin
                    if (mem_req) mem_ack = 1'b1;
                    else io_ack = 1'b1;
                end
                wcnt++;
            end
        end
        e = exp_q.pop_front();
        if (s_mem && !s_rd && !s_wr)      obs_kind = s_we ? 1 : 0;
        else if (s_rd && !s_mem && !s_wr) obs_kind = 2;
        else if (s_wr && !s_mem && !s_rd) obs_kind = 3;
        else                              obs_kind = 7;
        e_addr = (e.exp_kind >= 2) ? {4'h0, e.addr[15:0]} : e.addr;
        check($sformatf("%s ce_seen", tag), got, 1);
        check($sformatf("%s ce_clock", tag), lat, e.exp_lat);
        check($sformatf("%s core_in", tag), core_in, e.exp_core_in);
        check($sformatf("%s req_kind", tag), obs_kind, e.exp_kind);
        check($sformatf("%s req_addr", tag), o_addr, e_addr);
        check($sformatf("%s req_clocks", tag), req_clks, e.exp_req_clks);
        check($sformatf("%s bus_err_pulses", tag), errs, e.exp_err);
        if (e.exp_kind == 1 || e.exp_kind == 3)
            check($sformatf("%s wdata", tag), o_wd, e.wdata);
    endtask

    task automatic release_with(input vec_t v, input string tag);
        @(posedge clock);
        drive(v);
        #1 reset_n = 1'b1;
        wait_step(tag);
    endtask

    initial begin
        vec_t tbl[9];
        vec_t rv;
        int   k;
        int   cyc;
        int   prev;
        int   pulses;

        //          pw pr we addr       wdata waits rdata  spur lat core_in kind reqclk err
        tbl[0] = '{0, 0, 0, 20'h00100, 8'h00,  0, 8'hB8, 0,  3, 8'hB8, 0, 1, 0};
        tbl[1] = '{0, 0, 1, 20'hFFFFF, 8'h5A,  2, 8'h00, 0,  5, 8'h5A, 1, 3, 0};
        tbl[2] = '{1, 1, 1, 20'h00060, 8'h33,  1, 8'hEE, 0,  4, 8'h5A, 3, 2, 0};
        tbl[3] = '{0, 1, 0, 20'hA03F8, 8'h44,  0, 8'h7E, 0,  3, 8'h7E, 2, 1, 0};
        tbl[4] = '{0, 0, 0, 20'h12345, 8'h00, -1, 8'h99, 0,  7, 8'hFF, 0, 5, 1};
        tbl[5] = '{0, 0, 0, 20'h00000, 8'h00,  3, 8'h00, 1,  6, 8'h00, 0, 4, 0};
        tbl[6] = '{1, 0, 0, 20'h0F0F0, 8'h11, -1, 8'h22, 0,  7, 8'hFF, 3, 5, 1};
        tbl[7] = '{0, 0, 0, 20'h54321, 8'h00,  4, 8'hC3, 0,  7, 8'hC3, 0, 5, 0};
        tbl[8] = '{0, 0, 1, 20'h0ABCD, 8'hA5,  0, 8'h00, 0,  3, 8'hA5, 1, 1, 0};
        rv     = '{0, 0, 0, 20'h00200, 8'h00,  2, 8'h9C, 1,  5, 8'h9C, 0, 3, 0};

        reset_n    = 1'b0;
        b_reset_n  = 1'b0;
        address    = 20'h0; core_out = 8'h0; core_we = 0; core_pr = 0; core_pw = 0;
        mem_rdata  = 8'h0; io_rdata = 8'h0; mem_ack = 0; io_ack = 0;
        b_address  = 20'h00010; b_core_out = 8'h0; b_core_we = 0; b_core_pr = 0; b_core_pw = 0;
        cur        = tbl[0];

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset ce", ce, 0);
        check("reset requests", {mem_req, mem_we, io_rd, io_wr, bus_err}, 5'b0);
        check("reset core_in", core_in, 8'hFF);
        check("reset mem_address", mem_address, 20'h0);
        check("reset io_port", io_port, 16'h0);
        check("reset wdata", {mem_wdata, io_wdata}, 16'h0);

        release_with(tbl[0], "vec0");
        for (int i = 1; i < 9; i++) begin
            drive(tbl[i]);
            wait_step($sformatf("vec%0d", i));
        end

        // Reset while a memory request is outstanding.
        address = 20'h0ABC0; core_we = 0; core_pr = 0; core_pw = 0;
        mem_ack = 1'b0; io_ack = 1'b0;
        cur.waits = -1;
        k = 0;
        while (!mem_req && k < 10) begin
            @(negedge clock);
            k++;
        end
        check("reset_mid req_raised", mem_req, 1);
        reset_n = 1'b0;
        @(negedge clock);
        check("reset_mid mem_req", mem_req, 0);
        check("reset_mid ce", ce, 0);
        check("reset_mid core_in", core_in, 8'hFF);
        repeat (2) begin
            @(negedge clock);
            check("reset_mid ce_held", ce, 0);
        end
        release_with(rv, "post_reset");

        // Throttled instance: steady-state ce spacing and data.
        @(posedge clock);
        #1 b_reset_n = 1'b1;
        b_exp_q.push_back(b_address[7:0]);
        cyc = 0; prev = -1; pulses = 0;
        while (pulses < 9 && cyc < 400) begin
            @(negedge clock);
            cyc++;
            if (b_ce) begin
                check($sformatf("throttle data%0d", pulses), b_core_in, b_exp_q.pop_front());
                if (prev >= 0)
                    check($sformatf("throttle gap%0d", pulses), cyc - prev, 10);
                prev = cyc;
                pulses++;
                b_address = b_address + 20'h1;
                b_exp_q.push_back(b_address[7:0]);
            end
        end
        check("throttle pulse_count", pulses, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
